mem_req_responder: RTL

- Memory-side responder for the pipeline's two memory initiators: the instruction fetch port (read-only) and the MEM-stage data port (read/write).
- Owns a single-ported 16-bit word-addressed backing array.
- Arbitrates between the two ports and serves one transaction at a time with a fixed, parameterised latency.
- Returns per-port ack pulses and stall levels that the hazard/stall logic uses to freeze the pipeline.

---
 rtl/mem_req_if.sv | 30 +++
 rtl/mem_req_responder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mem_req_if.sv
// Bundles the fetch and data request/response signals between the pipeline
// initiators (master) and the memory responder (slave).
interface mem_req_if;
    // Handshake: a master raises *_req with address/we/wdata stable and holds it
    // until the matching *_ack pulses for one cycle. *_rdata and d_err are only
    // meaningful in that ack cycle. *_stall = *_req & ~*_ack.
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_rdata;
    logic        i_ack;
    logic        i_stall;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic [15:0] d_rdata;
    logic        d_ack;
    logic        d_stall;
    logic        d_err;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, d_err
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_rdata, i_ack, i_stall, d_rdata, d_ack, d_stall, d_err
    );
endinterface

// File: rtl/mem_req_responder.sv
// Single-ported 16-bit memory serving a fetch port and a data port, one
// transaction at a time with fixed latency. Optional: MEM_RANGE_CHECK_EN.
module mem_req_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_req_if.slave    bus,
    output logic [1:0]  dbg_state
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
`ifdef MEM_RANGE_CHECK_EN
    localparam bit RANGE_CHECK = 1'b1;
`else
    localparam bit RANGE_CHECK = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

    logic [15:0] mem [DEPTH];

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    port_e                   last_grant_q, last_grant_d;
    port_e                   port_q, port_d;
    logic                    we_q, we_d;
    logic [DEPTH_LOG2-1:0]   addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic                    oob_q, oob_d;
    logic                    i_ack_q, i_ack_d;
    logic                    d_ack_q, d_ack_d;
    logic [15:0]             i_rdata_q, i_rdata_d;
    logic [15:0]             d_rdata_q, d_rdata_d;
    logic                    d_err_q, d_err_d;
    logic                    mem_we;
    port_e                   grant;

    function automatic logic out_of_range(input logic [15:0] a);
        return RANGE_CHECK && ((32'(a) >> DEPTH_LOG2) != 32'd0);
    endfunction

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        port_d       = port_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        oob_d        = oob_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        d_err_d      = 1'b0;
        mem_we       = 1'b0;
        grant        = PORT_INSTR;

        if (bus.i_req && bus.d_req) begin
            grant = (last_grant_q == PORT_DATA) ? PORT_INSTR : PORT_DATA;
        end else if (bus.d_req) begin
            grant = PORT_DATA;
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    port_d       = grant;
                    last_grant_d = grant;
                    cnt_d        = 4'(LATENCY - 1);
                    state_d      = ST_BUSY;
                    if (grant == PORT_DATA) begin
                        addr_d  = bus.d_addr[DEPTH_LOG2-1:0];
                        we_d    = bus.d_we;
                        wdata_d = bus.d_wdata;
                        oob_d   = out_of_range(bus.d_addr);
                    end else begin
                        addr_d  = bus.i_addr[DEPTH_LOG2-1:0];
                        we_d    = 1'b0;
                        oob_d   = out_of_range(bus.i_addr);
                    end
                end
            end
            ST_BUSY: begin
                // BUSY spans LATENCY cycles so the response edge is accept+LATENCY.
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (port_q == PORT_DATA) begin
                        d_ack_d = 1'b1;
                        d_err_d = oob_q;
                        if (we_q) begin
                            mem_we = ~oob_q;
                        end else begin
                            d_rdata_d = oob_q ? 16'hDEAD : mem[addr_q];
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = oob_q ? 16'hDEAD : mem[addr_q];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= PORT_INSTR;
            port_q       <= PORT_INSTR;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= 16'h0000;
            oob_q        <= 1'b0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            i_rdata_q    <= 16'h0000;
            d_rdata_q    <= 16'h0000;
            d_err_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            port_q       <= port_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            oob_q        <= oob_d;
            i_ack_q      <= i_ack_d;
            d_ack_q      <= d_ack_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            d_err_q      <= d_err_d;
        end
    end

    // Array is not reset; a reset edge aborts any pending write.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.i_ack   = i_ack_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_err   = d_err_q;
    assign bus.i_stall = bus.i_req & ~i_ack_q;
    assign bus.d_stall = bus.d_req & ~d_ack_q;
    assign dbg_state   = state_q;

endmodule
